prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 99 +++++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: 16 x 8 program store, filled over a valid/ready byte stream and read combinationally by the CPU.
// Optional macro PROG_LOADER_CHECKSUM_EN appends a checksum byte (CHECK state) with an ERR outcome.
module prog_loader #(
   parameter logic [7:0] INIT_WORD = 8'h00
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       load_start,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic [3:0] addr,
   output logic [3:0] opecode,
   output logic [3:0] imm,
   output logic       loading,
   output logic       cpu_run,
   output logic       load_err
);

`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

   state_t     state;
   logic [3:0] wr_ptr;
   logic [7:0] mem [16];

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   assign din_ready = (state == LOAD) || (state == CHECK);
`else
   assign din_ready = (state == LOAD);
   assign load_err  = 1'b0;
`endif

   assign opecode = mem[addr][7:4];
   assign imm     = mem[addr][3:0];

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state   <= IDLE;
         wr_ptr  <= 4'd0;
         loading <= 1'b0;
         cpu_run <= 1'b0;
         for (int i = 0; i < 16; i++) mem[i] <= INIT_WORD;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum      <= 8'd0;
         load_err <= 1'b0;
`endif
      end else if (load_start) begin
         // Restart wins over any transfer presented in the same cycle.
         state   <= LOAD;
         wr_ptr  <= 4'd0;
         loading <= 1'b1;
         cpu_run <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum      <= 8'd0;
         load_err <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               if (din_valid) begin
                  mem[wr_ptr] <= din;
                  wr_ptr      <= wr_ptr + 4'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum <= sum + din;
                  if (wr_ptr == 4'd15) state <= CHECK;
`else
                  if (wr_ptr == 4'd15) begin
                     state   <= DONE;
                     loading <= 1'b0;
                     cpu_run <= 1'b1;
                  end
`endif
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
               if (din_valid) begin
                  loading <= 1'b0;
                  if (din == sum) begin
                     state   <= DONE;
                     cpu_run <= 1'b1;
                  end else begin
                     state    <= ERR;
                     load_err <= 1'b1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized bench for prog_loader with a behavioural model and per-cycle compare.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       load_start = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic [3:0] addr = 4'd0;
   logic [3:0] opecode;
   logic [3:0] imm;
   logic       loading;
   logic       cpu_run;
   logic       load_err;

   int checks = 0;
   int errors = 0;
   int xfers = 0;
   bit cmp_en = 1'b0;

   prog_loader #(.INIT_WORD(8'h00)) dut (
      .clk(clk), .n_reset(n_reset), .load_start(load_start),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .addr(addr), .opecode(opecode), .imm(imm),
      .loading(loading), .cpu_run(cpu_run), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a load is a count of accepted words, then (optionally) one checksum byte.
   logic [7:0] mm [16];
   bit         m_busy, m_sum_phase, m_run, m_err;
   int         m_n;
   logic [7:0] m_sum;

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 16; i++) mm[i] = 8'h00;
         m_busy = 0; m_sum_phase = 0; m_run = 0; m_err = 0; m_n = 0; m_sum = 8'h00;
      end else if (load_start) begin
         m_busy = 1; m_sum_phase = 0; m_run = 0; m_err = 0; m_n = 0; m_sum = 8'h00;
      end else if (m_busy && din_valid) begin
         if (!m_sum_phase) begin
            mm[m_n] = din;
            m_sum   = m_sum + din;
            m_n++;
            if (m_n == 16) begin
               m_n = 0;
`ifdef PROG_LOADER_CHECKSUM_EN
               m_sum_phase = 1;
`else
               m_busy = 0; m_run = 1;
`endif
            end
         end else begin
            m_busy = 0;
            if (din == m_sum) m_run = 1;
            else m_err = 1;
         end
      end
   end

   always @(posedge clk)
      if (n_reset && din_valid && din_ready && !load_start) xfers++;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("word", {opecode, imm}, mm[addr]);
         chk("din_ready", 8'(din_ready), 8'(m_busy));
         chk("loading", 8'(loading), 8'(m_busy));
         chk("cpu_run", 8'(cpu_run), 8'(m_run));
         chk("load_err", 8'(load_err), 8'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1; din_valid = 1'b0;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit rnd);
      int  guard = 0;
      bit  done = 0;
      while (!done && guard < 100) begin
         din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         din       = din_valid ? w : 8'($urandom);
         addr      = 4'($urandom);
         done      = din_valid && din_ready;
         tick();
         guard++;
      end
      din_valid = 1'b0;
      if (!done) chk("send_timeout", 8'd0, 8'd1);
   endtask

   task automatic sweep(input string nm, input logic [7:0] e [16]);
      for (int i = 0; i < 16; i++) begin
         addr = 4'(i);
         #1;
         chk(nm, {opecode, imm}, e[i]);
      end
   endtask

   function automatic logic [7:0] sum8(input logic [7:0] w [16]);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 16; i++) s = s + w[i];
      return s;
   endfunction

   task automatic load_prog(input logic [7:0] w [16], input bit rnd);
      pulse_start();
      for (int i = 0; i < 16; i++) send_word(w[i], rnd);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(sum8(w), rnd);
`endif
   endtask

   logic [7:0] zeros [16];
   logic [7:0] prog_a [16];
   logic [7:0] sent [16];
   logic [7:0] exp_w [16];
   int         base;

   initial begin
      for (int i = 0; i < 16; i++) zeros[i] = 8'h00;
      prog_a = '{8'h60, 8'h90, 8'h3F, 8'h01, 8'hE3, 8'h51, 8'hE1, 8'hB0,
                 8'hBF, 8'hF7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_run", 8'(cpu_run), 8'd0);
      chk("rst_din_ready", 8'(din_ready), 8'd0);
      chk("rst_loading", 8'(loading), 8'd0);
      n_reset = 1'b1;
      tick();
      cmp_en = 1'b1;
      sweep("rst_sweep", zeros);
      chk("idle_cpu_run", 8'(cpu_run), 8'd0);
      chk("idle_din_ready", 8'(din_ready), 8'd0);

      // Fixed program, back to back
      load_prog(prog_a, 1'b0);
      chk("fixed_cpu_run", 8'(cpu_run), 8'd1);
      chk("fixed_loading", 8'(loading), 8'd0);
      addr = 4'd9;
      #1;
      chk("fixed_op9", 8'(opecode), 8'h0F);
      chk("fixed_imm9", 8'(imm), 8'h07);
      sweep("fixed_sweep", prog_a);

      // Random words with random din_valid gaps
      for (int i = 0; i < 16; i++) sent[i] = 8'($urandom);
      base = xfers;
      load_prog(sent, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
      chk("rnd_xfers", 8'(xfers - base), 8'd17);
`else
      chk("rnd_xfers", 8'(xfers - base), 8'd16);
`endif
      chk("rnd_cpu_run", 8'(cpu_run), 8'd1);
      sweep("rnd_sweep", sent);

      // Restart after 5 words; the transfer in the restart cycle is dropped
      exp_w = sent;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         exp_w[i] = 8'($urandom);
         send_word(exp_w[i], 1'b0);
      end
      load_start = 1'b1; din_valid = 1'b1; din = 8'hAA;
      tick();
      load_start = 1'b0; din_valid = 1'b0;
      sweep("restart_keep", exp_w);
      send_word(8'h5C, 1'b0);
      exp_w[0] = 8'h5C;
      sweep("restart_first", exp_w);
      for (int i = 1; i < 16; i++) begin
         exp_w[i] = 8'($urandom);
         send_word(exp_w[i], 1'b1);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(sum8(exp_w), 1'b1);
`endif
      chk("restart_cpu_run", 8'(cpu_run), 8'd1);
      sweep("restart_done", exp_w);

`ifdef PROG_LOADER_CHECKSUM_EN
      // Bad checksum: 16 x 8'h01 sums to 8'h10, so 8'h11 must fail
      pulse_start();
      for (int i = 0; i < 16; i++) send_word(8'h01, 1'b0);
      send_word(8'h11, 1'b0);
      chk("err_load_err", 8'(load_err), 8'd1);
      chk("err_cpu_run", 8'(cpu_run), 8'd0);
      chk("err_loading", 8'(loading), 8'd0);
      pulse_start();
      chk("err_cleared", 8'(load_err), 8'd0);
      chk("err_reload", 8'(loading), 8'd1);
`endif

      // Reset in the middle of a load at wr_ptr = 8
      pulse_start();
      for (int i = 0; i < 8; i++) send_word(8'($urandom), 1'b0);
      n_reset = 1'b0;
      #1;
      chk("midrst_loading", 8'(loading), 8'd0);
      chk("midrst_din_ready", 8'(din_ready), 8'd0);
      chk("midrst_cpu_run", 8'(cpu_run), 8'd0);
      sweep("midrst_sweep", zeros);
      tick();
      n_reset = 1'b1;
      tick();
      chk("post_rst_loading", 8'(loading), 8'd0);

      // Random soak with occasional restarts
      for (int c = 0; c < 800; c++) begin
         load_start = ($urandom_range(0, 39) == 0);
         din_valid  = 1'($urandom_range(0, 1));
         din        = ($urandom_range(0, 3) == 0) ? m_sum : 8'($urandom);
         addr       = 4'($urandom);
         tick();
      end
      load_start = 1'b0; din_valid = 1'b0;
      tick();

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
